// File: rtl/timer_pkg.sv
// Shared definitions for the timer configuration sequencer.
// Register map, sequencer/transfer state encodings and error codes.
package timer_pkg;

    localparam logic [11:0] TCR_OFS  = 12'h001;
    localparam logic [11:0] TSR_OFS  = 12'h002;
    localparam logic [11:0] TMIN_OFS = 12'h005;
    localparam logic [11:0] TMAX_OFS = 12'h006;

    typedef enum logic [2:0] {
        IDLE,
        W_MAX,
        W_MIN,
        W_TCR,
        WAIT,
        RD_TSR,
        CLR_TSR,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SLVERR,
        ERR_TIMEOUT,
        ERR_ABORT
    } err_code_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_t;

endpackage

// File: rtl/apb_xfer_master.sv
// Single APB transfer engine: SETUP then ACCESS until pready.
// Address, data and direction are captured on req and held stable.
module apb_xfer_master
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    input  logic                  write,
    output logic                  ack,
    output logic [7:0]            rdata,
    output logic                  slverr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [7:0]            pwdata,
    input  logic [7:0]            prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    xfer_t ph, ph_nx;

    always_ff @(posedge pclk) begin
        if (preset) begin
            ph     <= X_IDLE;
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else begin
            ph <= ph_nx;
            if (ph == X_IDLE && req) begin
                paddr  <= addr;
                pwdata <= wdata;
                pwrite <= write;
            end
        end
    end

    always_comb begin
        ph_nx = ph;
        unique case (ph)
            X_IDLE:   if (req) ph_nx = X_SETUP;
            X_SETUP:  ph_nx = X_ACCESS;
            X_ACCESS: if (pready) ph_nx = X_IDLE;
            default:  ph_nx = X_IDLE;
        endcase
    end

    assign psel    = (ph != X_IDLE);
    assign penable = (ph == X_ACCESS);
    assign ack     = (ph == X_ACCESS) && pready;
    assign rdata   = prdata;
    assign slverr  = ack && pslverr;

endmodule

// File: rtl/timer_cfg_seq.sv
// Programs TMAX/TMIN/TCR over APB, polls TSR until a masked hit,
// clears TSR and reports done, or reports slverr/timeout/abort.
module timer_cfg_seq
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int POLL_W     = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            cfg_tcr,
    input  logic [7:0]            cfg_max,
    input  logic [7:0]            cfg_min,
    input  logic [7:0]            cfg_flag_mask,
    input  logic [POLL_W-1:0]     poll_interval,
    input  logic [POLL_W-1:0]     timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [7:0]            pwdata,
    input  logic [7:0]            prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            tsr_snap
);

    state_t            st, nx, after;
    err_code_t         code_q, ev_code;
    logic [7:0]        tcr_q, max_q, min_q, mask_q;
    logic [POLL_W-1:0] pi_q, to_q, wcnt, pcnt;
    logic              pend, abort_q, abrt, hit, tmo, wait_end;
    logic              req, ack, slverr, x_write, err_ev;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [7:0]        x_wdata, rdata;

    apb_xfer_master #(.ADDR_WIDTH(ADDR_WIDTH)) u_xfer (
        .pclk    (pclk),
        .preset  (preset),
        .req     (req),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .write   (x_write),
        .ack     (ack),
        .rdata   (rdata),
        .slverr  (slverr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    assign abrt     = abort || abort_q;
    assign hit      = |(rdata & mask_q);
    assign wait_end = ({1'b0, wcnt} + (POLL_W+1)'(1)) >= {1'b0, pi_q};
    assign tmo      = (to_q != '0) &&
                      (({1'b0, pcnt} + (POLL_W+1)'(1)) >= {1'b0, to_q});

    always_comb begin
        nx      = st;
        after   = st;
        req     = 1'b0;
        x_addr  = '0;
        x_wdata = '0;
        x_write = 1'b0;
        err_ev  = 1'b0;
        ev_code = ERR_NONE;
        unique case (st)
            W_MAX: begin
                x_addr  = ADDR_WIDTH'(TMAX_OFS);
                x_wdata = max_q;
                x_write = 1'b1;
                after   = W_MIN;
            end
            W_MIN: begin
                x_addr  = ADDR_WIDTH'(TMIN_OFS);
                x_wdata = min_q;
                x_write = 1'b1;
                after   = W_TCR;
            end
            W_TCR: begin
                x_addr  = ADDR_WIDTH'(TCR_OFS);
                x_wdata = tcr_q;
                x_write = 1'b1;
                after   = WAIT;
            end
            RD_TSR: begin
                x_addr = ADDR_WIDTH'(TSR_OFS);
                after  = hit ? CLR_TSR : (tmo ? IDLE : WAIT);
            end
            CLR_TSR: begin
                x_addr  = ADDR_WIDTH'(TSR_OFS);
                x_write = 1'b1;
                after   = FIN;
            end
            default: ;
        endcase

        if (st == IDLE) begin
            if (start) nx = W_MAX;
        end else if (st == FIN) begin
            nx = IDLE;
        end else if (st == WAIT) begin
            if (abrt) begin
                nx      = IDLE;
                err_ev  = 1'b1;
                ev_code = ERR_ABORT;
            end else if (wait_end) begin
                nx = RD_TSR;
            end
        end else if (!pend) begin
            // Abort before the transfer is issued: nothing in flight.
            if (abrt) begin
                nx      = IDLE;
                err_ev  = 1'b1;
                ev_code = ERR_ABORT;
            end else begin
                req = 1'b1;
            end
        end else if (ack) begin
            if (slverr) begin
                nx      = IDLE;
                err_ev  = 1'b1;
                ev_code = ERR_SLVERR;
            end else if (abrt) begin
                nx      = IDLE;
                err_ev  = 1'b1;
                ev_code = ERR_ABORT;
            end else begin
                nx = after;
                if (st == RD_TSR && !hit && tmo) begin
                    err_ev  = 1'b1;
                    ev_code = ERR_TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            st       <= IDLE;
            code_q   <= ERR_NONE;
            err      <= 1'b0;
            pend     <= 1'b0;
            abort_q  <= 1'b0;
            tsr_snap <= '0;
            tcr_q    <= '0;
            max_q    <= '0;
            min_q    <= '0;
            mask_q   <= '0;
            pi_q     <= '0;
            to_q     <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
        end else begin
            st  <= nx;
            err <= err_ev;
            if (st == IDLE && start) begin
                tcr_q  <= cfg_tcr;
                max_q  <= cfg_max;
                min_q  <= cfg_min;
                mask_q <= cfg_flag_mask;
                pi_q   <= poll_interval;
                to_q   <= timeout;
                code_q <= ERR_NONE;
                pcnt   <= '0;
            end
            if (err_ev) code_q <= ev_code;
            if (nx == IDLE) abort_q <= 1'b0;
            else if (abort && st != IDLE) abort_q <= 1'b1;
            if (req) pend <= 1'b1;
            else if (ack) pend <= 1'b0;
            wcnt <= (st == WAIT) ? wcnt + POLL_W'(1) : '0;
            if (st == RD_TSR && ack) begin
                tsr_snap <= rdata;
                // Poll counter saturates instead of wrapping.
                if (!slverr && !hit && pcnt != {POLL_W{1'b1}})
                    pcnt <= pcnt + POLL_W'(1);
            end
        end
    end

    assign busy     = (st != IDLE);
    assign done     = (st == FIN);
    assign err_code = code_q;

endmodule

// File: doc/timer_cfg_seq.md
TIMER_CFG_SEQ -- requirements
Module: timer_cfg_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter POLL_W, default 16, width of the poll-interval and timeout counters.
REQ-003 SHALL have ports pclk (in, 1, sole clock) and preset (in, 1, reset; synchronous, active-high).
REQ-004 SHALL have ports start (in, 1, one-cycle sequence request) and abort (in, 1, stop request).
REQ-005 SHALL have ports cfg_tcr, cfg_max, cfg_min (in, 8 each, values for TCR, TMAX, TMIN) and cfg_flag_mask (in, 8, TSR bits that count as a hit).
REQ-006 SHALL have ports poll_interval (in, POLL_W, idle cycles between TSR reads) and timeout (in, POLL_W, maximum number of TSR reads; 0 = unlimited).
REQ-007 SHALL have APB master ports psel, penable, pwrite (out, 1 each), paddr (out, ADDR_WIDTH), pwdata (out, 8), prdata (in, 8), pready (in, 1), pslverr (in, 1).
REQ-008 SHALL have status ports busy (out, 1), done (out, 1, one-cycle pulse), err (out, 1, one-cycle pulse), err_code (out, 2: 0 none, 1 slverr, 2 timeout, 3 abort) and tsr_snap (out, 8, last TSR read).

Function
REQ-009 SHALL implement states IDLE, W_MAX, W_MIN, W_TCR, WAIT, RD_TSR, CLR_TSR, FIN.
REQ-010 SHALL latch all cfg_* inputs, poll_interval and timeout on start in IDLE; later changes to these inputs SHALL NOT affect the running sequence.
REQ-011 SHALL ignore start while busy=1.
REQ-012 SHALL step IDLE -> W_MAX (write cfg_max to 0x006) -> W_MIN (write cfg_min to 0x005) -> W_TCR (write cfg_tcr to 0x001) -> WAIT.
REQ-013 SHALL make every APB transfer one SETUP cycle (psel=1, penable=0) followed by ACCESS cycles (psel=1, penable=1) until pready=1; paddr, pwrite and pwdata SHALL stay stable for the whole transfer.
REQ-014 SHALL return psel and penable to 0 for at least one cycle between transfers.
REQ-015 SHALL count poll_interval cycles in WAIT, then go to RD_TSR; poll_interval=0 SHALL give exactly one idle cycle.
REQ-016 SHALL read 0x002 in RD_TSR and load prdata into tsr_snap in the cycle pready=1.
REQ-017 SHALL go to CLR_TSR when (prdata & mask)!=0; otherwise it SHALL increment the poll counter and return to WAIT.
REQ-018 SHALL write 0x00 to 0x002 in CLR_TSR, then go to FIN.
REQ-019 SHALL pulse done for one cycle in FIN, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-020 SHALL treat pslverr=1 on the completing cycle of any transfer as an error: err pulses with err_code=1, no further transfers, go to IDLE.
REQ-021 SHALL treat the poll count reaching a nonzero timeout without a hit as a timeout: err pulses with err_code=2, go to IDLE, TSR not cleared.
REQ-022 SHALL handle abort as follows: an in-flight transfer completes, then err pulses with err_code=3 and the FSM goes to IDLE; in WAIT, abort exits on the next cycle.
REQ-023 SHALL give abort and pslverr on the same completion precedence to pslverr.
REQ-024 SHALL ignore abort in IDLE.
REQ-025 SHALL hold err_code until the next start; done and err SHALL never assert together.
REQ-026 SHALL make the poll counter saturate rather than wrap.

Reset
REQ-027 SHALL set state=IDLE; psel, penable, pwrite, done, err, busy = 0; paddr, pwdata, tsr_snap, err_code and all counters = 0.
REQ-028 SHALL abandon any in-flight transfer on preset asserted mid-sequence, with psel=0 on the next cycle.

Structure
REQ-029 SHALL define in a shared package timer_pkg: register offsets (TCR 0x001, TSR 0x002, TMIN 0x005, TMAX 0x006), the state enum and the err_code enum.
REQ-030 SHALL place the APB transfer handshake in sub-module apb_xfer_master (req/addr/wdata/write in; ack/rdata/slverr out); sequencing stays in timer_cfg_seq.

Verification
REQ-031 SHALL cover: start with max=0x20, min=0x10, tcr=0x3A, pready tied 1 -> writes 0x006=0x20, 0x005=0x10, 0x001=0x3A, each 2 cycles with 1 idle gap.
REQ-032 SHALL cover: mask=0x01, model TSR returns 0x00 three times then 0x01 -> exactly 4 reads spaced poll_interval+1 idle cycles, write 0x002=0x00, done pulse, tsr_snap=0x01.
REQ-033 SHALL cover: pready low 3 cycles on W_MIN -> ACCESS lasts 4 cycles with paddr and pwdata stable, sequence continues.
REQ-034 SHALL cover: pslverr=1 on W_TCR -> err with err_code=1, no TSR read, busy=0 next cycle.
REQ-035 SHALL cover: timeout=5 with TSR always 0x00 -> 5 reads, err with err_code=2, no TSR write.
REQ-036 SHALL cover: abort during W_MAX ACCESS with pready delayed -> transfer completes, err_code=3; preset in RD_TSR -> all outputs 0 next cycle.
